// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame layout and line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // Serial frame as it sits in the shift register: start bit in bit 0, stop bit on top.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {STOP_BIT, data, START_BIT};
  endfunction

endpackage

// File: rtl/uart_tx_holdreg.sv
// One-deep valid/ready holding register that buffers the next byte while a frame is on the line.
module uart_tx_holdreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic accept;

  assign in_ready = !full;
  assign accept   = in_valid && !full;

  // Capture on handshake; a capture outranks a same-cycle take so a fresh byte is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (accept) begin
        data <= in_data;
        full <= 1'b1;
      end else if (take) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pending byte buffer, IDLE/LOAD/SHIFT sequencer, 10-bit shifter and tick watchdog.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int WDOG_TICKS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       bit_done,
  output logic       shift_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_err
);

  localparam logic [3:0] WDOG_LIMIT = 4'(WDOG_TICKS);

  tx_state_t             state;
  tx_state_t             state_nxt;
  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] sr_nxt;
  logic [3:0]            tick_cnt;
  logic [3:0]            tick_cnt_nxt;
  logic                  first_shift;
  logic                  frame_err_nxt;
  logic                  load_take;
  logic                  wdog_hit;
  logic                  pend_full;
  logic [7:0]            pend_data;

  uart_tx_holdreg #(.WIDTH(8)) u_holdreg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (tx_valid),
    .in_data  (tx_data),
    .in_ready (tx_ready),
    .take     (load_take),
    .full     (pend_full),
    .data     (pend_data)
  );

  assign wdog_hit = (tick_cnt == WDOG_LIMIT);
  assign tx       = (state == SHIFT) ? sr[0] : IDLE_LEVEL;
  assign busy     = (state != IDLE);

  // Next state, shifter and tick counter; bit_done beats both the watchdog and a coincident tick.
  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    tick_cnt_nxt  = tick_cnt;
    load_take     = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pend_full) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        sr_nxt       = build_frame(pend_data);
        tick_cnt_nxt = '0;
        load_take    = 1'b1;
        state_nxt    = SHIFT;
      end
      SHIFT: begin
        if (bit_done) begin
          state_nxt = IDLE;
        end else if (wdog_hit) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
          sr_nxt        = '1;
        end else if (baud_tick && !first_shift) begin
          sr_nxt = {IDLE_LEVEL, sr[FRAME_BITS-1:1]};
          if (tick_cnt < WDOG_LIMIT) begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; shift_en is registered from the next state so it tracks SHIFT exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '1;
      tick_cnt    <= '0;
      first_shift <= 1'b0;
      shift_en    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      sr          <= sr_nxt;
      tick_cnt    <= tick_cnt_nxt;
      first_shift <= (state == LOAD);
      shift_en    <= (state_nxt == SHIFT);
      frame_err   <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: vector table for handshake timing plus frame-level sequences.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       bit_done;
  logic       shift_en;
  logic       tx;
  logic       busy;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       t;
    logic       b;
    logic       ready;
    logic       busy;
    logic       tx;
    logic       sen;
  } vec_t;

  vec_t vecs[13];

  uart_tx_ctrl #(.WDOG_TICKS(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .bit_done  (bit_done),
    .shift_en  (shift_en),
    .tx        (tx),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Line level of bit k of a frame for byte d: start 0, data LSB first, stop 1.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return ((int'(d) >> (k - 1)) % 2) == 1;
  endfunction

  // Contents of the 10-bit frame register after n right shifts with ones shifted in.
  function automatic logic [9:0] sr_after(input logic [7:0] d, input int n);
    int f;
    int r;
    f = 512 + 2 * int'(d);
    r = (f >> n) | (1023 - (1023 >> n));
    return r[9:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic t, input logic b);
    tx_valid  = v;
    tx_data   = d;
    baud_tick = t;
    bit_done  = b;
  endtask

  task automatic offer(input logic [7:0] d);
    apply_stimulus(1'b1, d, 1'b0, 1'b0);
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_shift(input string name);
    for (int i = 0; i < 8 && !shift_en; i++) step();
    check_output(name, shift_en, 1'b1);
  endtask

  // mode 0: first SHIFT clk already used; 1: idle first SHIFT clk; 2: tick in first SHIFT clk (ignored).
  task automatic shift_ticks(input logic [7:0] d, input int n, input int mode);
    if (mode == 1) begin
      step();
    end else if (mode == 2) begin
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
      check_output("first_tick_sr", dut.sr, sr_after(d, 0));
      check_output("first_tick_tx", tx, 1'b0);
    end
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) step();
      check_output($sformatf("tx_bit%0d", k), tx, (k < 10) ? frame_bit(d, k) : 1'b1);
      check_output($sformatf("no_ferr%0d", k), frame_err, 1'b0);
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
    end
  endtask

  task automatic finish_frame(input string name);
    bit_done = 1'b1;
    step();
    bit_done = 1'b0;
    check_output({name, "_busy"}, busy, 1'b0);
    check_output({name, "_tx"}, tx, 1'b1);
    check_output({name, "_sen"}, shift_en, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] p;
    int         seen;
    int         bad;

    vecs[0]  = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check_output("rst_tx", tx, 1'b1);
    check_output("rst_sen", shift_en, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_ferr", frame_err, 1'b0);
    check_output("rst_ready", tx_ready, 1'b1);
    check_output("rst_sr", dut.sr, 10'h3FF);

    $display("[TB] vector table");
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].v, vecs[i].d, vecs[i].t, vecs[i].b);
      step();
      check_output($sformatf("vec%0d_ready", i), tx_ready, vecs[i].ready);
      check_output($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check_output($sformatf("vec%0d_tx", i), tx, vecs[i].tx);
      check_output($sformatf("vec%0d_sen", i), shift_en, vecs[i].sen);
      check_output($sformatf("vec%0d_ferr", i), frame_err, 1'b0);
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    $display("[TB] frame A5");
    offer(8'hA5);
    wait_shift("a5_start");
    shift_ticks(8'hA5, 10, 1);
    finish_frame("a5_end");

    $display("[TB] back-to-back with pending 3C");
    d = 8'($urandom);
    offer(d);
    wait_shift("b2b_start");
    check_output("b2b_ready_before", tx_ready, 1'b1);
    offer(8'h3C);
    check_output("b2b_ready_after_3c", tx_ready, 1'b0);
    offer(8'h00);
    check_output("b2b_ready_after_00", tx_ready, 1'b0);
    shift_ticks(d, 10, 0);
    finish_frame("b2b_first_end");
    step();
    check_output("gap2_busy", busy, 1'b1);
    check_output("gap2_sen", shift_en, 1'b0);
    check_output("gap2_tx", tx, 1'b1);
    step();
    check_output("gap_done_sen", shift_en, 1'b1);
    check_output("gap_done_sr", dut.sr, sr_after(8'h3C, 0));
    shift_ticks(8'h3C, 10, 1);
    finish_frame("b2b_3c_end");

    $display("[TB] tick in first SHIFT clk");
    d = 8'($urandom);
    offer(d);
    wait_shift("ign_start");
    shift_ticks(d, 10, 2);
    check_output("ign_busy_after10", busy, 1'b1);
    check_output("ign_sr_after10", dut.sr, sr_after(d, 10));
    finish_frame("ign_end");

    $display("[TB] bit_done with baud_tick");
    d = 8'($urandom);
    offer(d);
    wait_shift("both_start");
    shift_ticks(d, 4, 1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1);
    step();
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("both_busy", busy, 1'b0);
    check_output("both_sen", shift_en, 1'b0);
    check_output("both_sr", dut.sr, sr_after(d, 4));

    $display("[TB] watchdog");
    d = 8'($urandom);
    p = 8'($urandom);
    offer(d);
    wait_shift("wd_start");
    offer(p);
    shift_ticks(d, 12, 0);
    seen = 0;
    for (int i = 0; i < 4 && !frame_err; i++) step();
    if (frame_err) begin
      seen = 1;
      check_output("wd_busy", busy, 1'b0);
      check_output("wd_tx", tx, 1'b1);
      check_output("wd_pend_kept", tx_ready, 1'b0);
      step();
      check_output("wd_single_pulse", frame_err, 1'b0);
    end
    check_output("wd_pulse_seen", seen, 1);
    wait_shift("wd_pend_start");
    shift_ticks(p, 10, 1);
    finish_frame("wd_pend_end");

    $display("[TB] reset mid-frame");
    d = 8'($urandom);
    offer(d);
    wait_shift("mid_start");
    offer(8'h5A);
    shift_ticks(d, 4, 0);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_rst_tx", tx, 1'b1);
    check_output("mid_rst_sen", shift_en, 1'b0);
    check_output("mid_rst_ready", tx_ready, 1'b1);
    check_output("mid_rst_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check_output("no_frame_after_rst", bad, 0);

    $display("[TB] random frames");
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      offer(d);
      wait_shift($sformatf("rnd%0d_start", i));
      shift_ticks(d, 10, ($urandom_range(0, 1) == 1) ? 2 : 1);
      finish_frame($sformatf("rnd%0d_end", i));
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
